// File: rtl/park_gate_ctrl.sv
// Parking entry gate controller with internal occupancy count and password timer; PARK_LOCKOUT_EN adds wrong-password lockout.
// Moore outputs change on the same edge as the state (1-cycle latency from inputs); no backpressure, inputs are sampled every cycle.
module park_gate_ctrl #(
  parameter int CAPACITY    = 16,
  parameter int CNT_W       = 5,
  parameter int TIMEOUT_CYC = 100,
  parameter int TMR_W       = 8,
  parameter int MAX_TRIES   = 3
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             SE,
  input  logic             SI,
  input  logic             SS,
  input  logic             SenhaOk,
  input  logic             SenhaErr,
  output logic             Liberado,
  output logic             Pare,
  output logic             Bloqueado,
  output logic             Alarme,
  output logic [CNT_W-1:0] Ocupacao,
  output logic             Full
);

`ifdef PARK_LOCKOUT_EN
  typedef enum logic [2:0] {
    INICIAL      = 3'd0,
    ESPERA_SENHA = 3'd1,
    ESTACIONANDO = 3'd2,
    PARE         = 3'd3,
    BLOQUEADO    = 3'd4,
    LOCKOUT      = 3'd5
  } state_t;

  localparam int ERR_W = $clog2(MAX_TRIES + 1);
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`else
  typedef enum logic [2:0] {
    INICIAL      = 3'd0,
    ESPERA_SENHA = 3'd1,
    ESTACIONANDO = 3'd2,
    PARE         = 3'd3,
    BLOQUEADO    = 3'd4
  } state_t;
`endif

  localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  if ((2 ** CNT_W) <= CAPACITY) begin : g_bad_cnt_w
    $error("CNT_W too narrow for CAPACITY");
  end
  if ((2 ** TMR_W) < TIMEOUT_CYC) begin : g_bad_tmr_w
    $error("TMR_W too narrow for TIMEOUT_CYC");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("MAX_TRIES must be at least 1");
  end

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             passed_q, passed_d;
  logic             si_dly_q, si_dly_d;
  logic             ss_dly_q, ss_dly_d;
  logic             si_fall, ss_rise, tmr_done, full, inc, dec;

  assign si_dly_d = SI;
  assign ss_dly_d = SS;
  assign si_fall  = ~SI & si_dly_q;
  assign ss_rise  = SS & ~ss_dly_q;
  assign tmr_done = (timer_q == TMR_LAST);
  assign full     = (cnt_q == CAP_V);
  assign dec      = ss_rise;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q   <= INICIAL;
      timer_q   <= '0;
      cnt_q     <= '0;
      passed_q  <= 1'b0;
      si_dly_q  <= 1'b0;
      ss_dly_q  <= 1'b0;
`ifdef PARK_LOCKOUT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      passed_q  <= passed_d;
      si_dly_q  <= si_dly_d;
      ss_dly_q  <= ss_dly_d;
`ifdef PARK_LOCKOUT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    passed_d  = passed_q;
    inc       = 1'b0;
`ifdef PARK_LOCKOUT_EN
    err_cnt_d = err_cnt_q;
`endif
    case (state_q)
      INICIAL: begin
        if (full) begin
          state_d = BLOQUEADO;
        end else if (SE && SI) begin
          state_d = PARE;
        end else if (SE) begin
          state_d = ESPERA_SENHA;
          timer_d = '0;
        end
      end
      ESPERA_SENHA: begin
        if (full) begin
          state_d = BLOQUEADO;
        end else if (SenhaOk) begin
          state_d   = ESTACIONANDO;
          timer_d   = '0;
          passed_d  = 1'b0;
`ifdef PARK_LOCKOUT_EN
          err_cnt_d = '0;
`endif
        end else if (SenhaErr) begin
`ifdef PARK_LOCKOUT_EN
          // A wrong password either trips the lockout or restarts the entry window.
          err_cnt_d = err_cnt_q + ERR_W'(1);
          timer_d   = '0;
          if (err_cnt_q + ERR_W'(1) == ERR_W'(MAX_TRIES)) begin
            state_d = LOCKOUT;
          end
`else
          state_d = INICIAL;
`endif
        end else if (tmr_done) begin
          state_d = INICIAL;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ESTACIONANDO: begin
        passed_d = passed_q | SI;
        if (si_fall && passed_q) begin
          state_d = INICIAL;
          inc     = 1'b1;
        end else if (tmr_done && !passed_q) begin
          state_d = INICIAL;
        end else if (!passed_q) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      PARE: begin
        if (!SI) state_d = INICIAL;
      end
      BLOQUEADO: begin
        if (!full) state_d = INICIAL;
      end
`ifdef PARK_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr_done) begin
          state_d   = INICIAL;
          err_cnt_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
`endif
      default: state_d = INICIAL;
    endcase
  end

  // Simultaneous entry and exit cancel out; saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CAP_V)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    Liberado  = (state_q == ESTACIONANDO);
    Pare      = (state_q == PARE);
    Bloqueado = (state_q == BLOQUEADO);
`ifdef PARK_LOCKOUT_EN
    Alarme    = (state_q == LOCKOUT);
`else
    Alarme    = 1'b0;
`endif
    Ocupacao  = cnt_q;
    Full      = full;
  end

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Bench for park_gate_ctrl: vector table plus hand sequences, expectations queued at drive time and checked after each edge.
module tb_park_gate_ctrl;
  localparam int CAP   = 2;
  localparam int CNT_W = 3;
  localparam int TO    = 8;
  localparam int TMR_W = 4;
  localparam int MT    = 2;
`ifdef PARK_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic SE = 1'b0, SI = 1'b0, SS = 1'b0, SenhaOk = 1'b0, SenhaErr = 1'b0;
  logic Liberado, Pare, Bloqueado, Alarme, Full;
  logic [CNT_W-1:0] Ocupacao;

  always #5 CLK = ~CLK;

  park_gate_ctrl #(
    .CAPACITY(CAP), .CNT_W(CNT_W), .TIMEOUT_CYC(TO), .TMR_W(TMR_W), .MAX_TRIES(MT)
  ) dut (
    .CLK(CLK), .reset(reset), .SE(SE), .SI(SI), .SS(SS),
    .SenhaOk(SenhaOk), .SenhaErr(SenhaErr),
    .Liberado(Liberado), .Pare(Pare), .Bloqueado(Bloqueado), .Alarme(Alarme),
    .Ocupacao(Ocupacao), .Full(Full)
  );

  typedef struct {
    logic rst_n, se, si, ss, ok, er;
    logic lib, pare, bloq, alarm;
    logic [CNT_W-1:0] occ;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  function automatic void add(input logic r, se, si, ss, ok, er,
                              input logic lib, pare, bloq, alarm, input logic [CNT_W-1:0] occ);
    vec_t v;
    v.rst_n = r; v.se = se; v.si = si; v.ss = ss; v.ok = ok; v.er = er;
    v.lib = lib; v.pare = pare; v.bloq = bloq; v.alarm = alarm; v.occ = occ;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at step %0d: got %0h, expected %0h", name, step_no, act, exp);
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    reset = v.rst_n; SE = v.se; SI = v.si; SS = v.ss; SenhaOk = v.ok; SenhaErr = v.er;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk("Liberado",  {7'b0, Liberado},  {7'b0, e.lib});
    chk("Pare",      {7'b0, Pare},      {7'b0, e.pare});
    chk("Bloqueado", {7'b0, Bloqueado}, {7'b0, e.bloq});
    chk("Alarme",    {7'b0, Alarme},    {7'b0, e.alarm});
    chk("Ocupacao",  {5'b0, Ocupacao},  {5'b0, e.occ});
    chk("Full",      {7'b0, Full},      {7'b0, (int'(e.occ) == CAP)});
    step_no++;
  endtask

  task automatic drv(input logic r, se, si, ss, ok, er,
                     input logic lib, pare, bloq, alarm, input logic [CNT_W-1:0] occ);
    vec_t v;
    v.rst_n = r; v.se = se; v.si = si; v.ss = ss; v.ok = ok; v.er = er;
    v.lib = lib; v.pare = pare; v.bloq = bloq; v.alarm = alarm; v.occ = occ;
    step(v);
  endtask

  initial begin
    logic [CNT_W-1:0] o;
    o = LOCK ? 3'd1 : 3'd0;
    // reset
    add(0,0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0);
    // first entry
    add(1,1,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,0,1,0, 1,0,0,0,0);
    add(1,0,1,0,0,0, 1,0,0,0,0);
    add(1,0,1,0,0,0, 1,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,1);
    // second entry, full, blocked, exit
    add(1,1,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0,1,0, 1,0,0,0,1);
    add(1,0,1,0,0,0, 1,0,0,0,1);
    add(1,0,0,0,0,0, 0,0,0,0,2);
    add(1,1,0,0,0,0, 0,0,1,0,2);
    add(1,0,0,1,0,0, 0,0,1,0,1);
    add(1,0,0,0,0,0, 0,0,0,0,1);
    // password accepted on the last cycle of the window, then passage timeout
    add(1,1,0,0,0,0, 0,0,0,0,1);
    for (int i = 0; i < 7; i++) add(1,0,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0,1,0, 1,0,0,0,1);
    for (int i = 0; i < 7; i++) add(1,0,0,0,0,0, 1,0,0,0,1);
    add(1,0,0,0,0,0, 0,0,0,0,1);
    // password window expires after 8 cycles
    add(1,1,0,0,0,0, 0,0,0,0,1);
    for (int i = 0; i < 8; i++) add(1,0,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0,1,0, 0,0,0,0,1);
    // SE and SI together -> stop
    add(1,1,1,0,0,0, 0,1,0,0,1);
    add(1,0,1,0,0,0, 0,1,0,0,1);
    add(1,0,0,0,0,0, 0,0,0,0,1);
    // entry and exit on the same edge, then exits down to and past zero
    add(1,1,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0,1,0, 1,0,0,0,1);
    add(1,0,1,0,0,0, 1,0,0,0,1);
    add(1,0,0,1,0,0, 0,0,0,0,1);
    add(1,0,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,1,0,0, 0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,1,0,0, 0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,0);
    // password pulses ignored while idle; OK wins over ERR
    add(1,0,0,0,1,0, 0,0,0,0,0);
    add(1,0,0,0,0,1, 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,0,1,1, 1,0,0,0,0);
    add(1,0,1,0,0,0, 1,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,1);
    // single wrong password: retry window with lockout, abort without
    add(1,1,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0,0,1, 0,0,0,0,1);
    add(1,0,0,0,1,0, LOCK,0,0,0,1);
    add(1,0,1,0,0,0, LOCK,0,0,0,1);
    add(1,0,0,1,0,0, 0,0,0,0,o);
    add(1,0,0,0,0,0, 0,0,0,0,o);

    foreach (vecs[i]) step(vecs[i]);

    // reset while the car is leaving the gate area: no count update
    drv(1,1,0,0,0,0, 0,0,0,0,o);
    drv(1,0,0,0,1,0, 1,0,0,0,o);
    drv(1,0,1,0,0,0, 1,0,0,0,o);
    drv(0,0,0,0,0,0, 0,0,0,0,0);
    drv(1,0,0,0,0,0, 0,0,0,0,0);

`ifdef PARK_LOCKOUT_EN
    // OK clears the error count, so the next single error does not lock
    drv(1,1,0,0,0,0, 0,0,0,0,0);
    drv(1,0,0,0,0,1, 0,0,0,0,0);
    drv(1,0,0,0,1,0, 1,0,0,0,0);
    drv(1,0,1,0,0,0, 1,0,0,0,0);
    drv(1,0,0,0,0,0, 0,0,0,0,1);
    drv(1,1,0,0,0,0, 0,0,0,0,1);
    drv(1,0,0,0,0,1, 0,0,0,0,1);
    drv(1,0,0,0,0,1, 0,0,0,1,1);
    for (int i = 0; i < 7; i++) drv(1,0,0,0,0,0, 0,0,0,1,1);
    drv(1,0,0,0,0,0, 0,0,0,0,1);
    // lockout expiry cleared the count: two errors lock again, then reset aborts
    drv(1,1,0,0,0,0, 0,0,0,0,1);
    drv(1,0,0,0,0,1, 0,0,0,0,1);
    drv(1,0,0,0,0,1, 0,0,0,1,1);
    drv(1,0,0,0,0,0, 0,0,0,1,1);
    drv(0,0,0,0,0,0, 0,0,0,0,0);
    drv(1,0,0,0,0,0, 0,0,0,0,0);
`else
    drv(1,1,0,0,0,0, 0,0,0,0,0);
    drv(1,0,0,0,0,1, 0,0,0,0,0);
    drv(1,0,0,0,1,0, 0,0,0,0,0);
    drv(1,1,0,0,0,0, 0,0,0,0,0);
    drv(1,0,0,0,0,1, 0,0,0,0,0);
    drv(1,0,0,0,0,1, 0,0,0,0,0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/park_gate_ctrl.md
Name: park_gate_ctrl

Overview:
Parametrised parking-entry controller, successor to the single-gate entry FSM. Adds:
- an internal occupancy counter driven by entry completion and an exit sensor;
- an internal password-timeout timer, replacing the external Time input;
- explicit stop and full handling;
- optional lockout after repeated wrong passwords.

It sits between the gate sensors/keypad logic and the barrier/indicator drivers.

Parameters:
CAPACITY, 16, number of spaces; Full is asserted when count == CAPACITY
CNT_W, 5, occupancy counter width; must satisfy 2**CNT_W > CAPACITY
TIMEOUT_CYC, 100, cycles allowed for password entry and for car passage
TMR_W, 8, timer width; must satisfy 2**TMR_W >= TIMEOUT_CYC
MAX_TRIES, 3, wrong passwords before lockout (PARK_LOCKOUT_EN only)

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-low (0 = reset), sampled on CLK rising edge
SE  in  1  entry presence sensor, level
SI  in  1  gate-area/inside sensor, level
SS  in  1  exit sensor, level; a rising edge means one car has left
SenhaOk  in  1  one-cycle pulse, correct password
SenhaErr  in  1  one-cycle pulse, wrong password
Liberado  out  1  barrier open
Pare  out  1  stop light
Bloqueado  out  1  lot full indicator
Alarme  out  1  lockout alarm (constant 0 when feature is off)
Ocupacao  out  CNT_W  current occupancy count
Full  out  1  Ocupacao == CAPACITY, combinational from the counter

Behaviour:
- Reset (reset==0 at a CLK edge):
  - state=INICIAL; Ocupacao=0; timer=0; err_cnt=0; passed flag=0; SI/SS delay registers=0.
  - All 1-bit outputs are 0.
  - Reset mid-operation aborts any state immediately. No partial count update is made.
- Outputs are Moore decodes of the state register and change in the same edge as the state:
  - Liberado=1 only in ESTACIONANDO.
  - Pare=1 only in PARE.
  - Bloqueado=1 only in BLOQUEADO.
  - Alarme=1 only in LOCKOUT.
- SI and SS each have a one-cycle delay register. si_fall = ~SI & SI_d. ss_rise = SS & ~SS_d.
- Transitions (first matching condition wins):
  - INICIAL: Full -> BLOQUEADO; SE&SI -> PARE; SE -> ESPERA_SENHA (timer cleared).
  - ESPERA_SENHA:
    - Full -> BLOQUEADO
    - SenhaOk -> ESTACIONANDO (timer cleared, passed=0, err_cnt cleared)
    - SenhaErr -> see Optional Feature
    - timer==TIMEOUT_CYC-1 -> INICIAL
    - otherwise timer+1
  - ESTACIONANDO: SI sets passed=1.
    - si_fall & passed -> INICIAL, with count increment request.
    - timer==TIMEOUT_CYC-1 & ~passed -> INICIAL, no increment.
    - otherwise timer+1. The timer stops once passed=1.
  - PARE: ~SI -> INICIAL.
  - BLOQUEADO: ~Full -> INICIAL.
  - LOCKOUT: timer==TIMEOUT_CYC-1 -> INICIAL (err_cnt cleared); otherwise timer+1.
  - Unused encodings -> INICIAL.
- Occupancy counter:
  - inc = increment request from ESTACIONANDO; dec = ss_rise.
  - inc&dec in the same cycle: count unchanged.
  - inc at CAPACITY: saturate, no wrap.
  - dec at 0: stays 0, no underflow.
  - Exits (dec) are counted in every state, including LOCKOUT and BLOQUEADO.
- SenhaOk and SenhaErr are ignored outside ESPERA_SENHA. If both are asserted in the same cycle, SenhaOk wins.

Optional Feature:
Macro PARK_LOCKOUT_EN.
- Defined:
  - SenhaErr in ESPERA_SENHA increments err_cnt (width $clog2(MAX_TRIES+1)).
  - If err_cnt+1 == MAX_TRIES: -> LOCKOUT with timer cleared.
  - Otherwise: stay in ESPERA_SENHA with timer cleared (fresh entry window).
  - err_cnt persists across INICIAL visits. It is cleared only by SenhaOk, by LOCKOUT expiry, or by reset.
- Undefined:
  - SenhaErr -> INICIAL.
  - No err_cnt register, no LOCKOUT state; Alarme is tied to 0.

Test Plan:
Common settings: CAPACITY=2, TIMEOUT_CYC=8, MAX_TRIES=2.
1. Reset, then SE=1 for 1 cycle, SenhaOk pulse 3 cycles later, SI high 2 cycles then low -> Liberado=1 from the SenhaOk edge until the si_fall edge; Ocupacao 0->1; state returns to INICIAL.
2. Two full entries -> Ocupacao=2, Full=1. Next SE -> BLOQUEADO, Bloqueado=1. SS pulse -> Ocupacao=1, Bloqueado drops next edge.
3. SE=1 with no password -> ESPERA_SENHA for exactly 8 cycles, then INICIAL; Liberado never 1.
4. SE=1 & SI=1 together -> Pare=1 until SI=0, then Pare=0 next edge; Ocupacao unchanged.
5. si_fall in ESTACIONANDO coincident with an SS rise at Ocupacao=1 -> Ocupacao stays 1. SS rise at 0 -> stays 0.
6. PARK_LOCKOUT_EN defined: two SenhaErr pulses in ESPERA_SENHA -> LOCKOUT, Alarme=1 for 8 cycles, then INICIAL with err_cnt=0. Undefined: first SenhaErr -> INICIAL, Alarme always 0. Also drive reset=0 mid-LOCKOUT -> all outputs 0 on the next edge.
